// File: rtl/door_lock_controller.sv
// Keypad door lock: buffers a 4-digit BCD code and requests the motor sequencer to open on a match.
// Wrong codes raise a timed error indication; repeated failures trigger a timed lockout.
module door_lock_controller #(
  parameter logic [15:0] PASSWORD      = 16'h1234,
  parameter int          MAX_FAILS     = 3,
  parameter int          ERR_HOLD      = 12000000,
  parameter int          LOCKOUT_DELAY = 24000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_VALID,
  input  logic [3:0] KEY_CODE,
  input  logic       MOTOR_DONE,
  output logic       PW_OK,
  output logic       ERROR,
  output logic       LOCKED_OUT,
  output logic [2:0] DIGIT_CNT,
  output logic [1:0] FAIL_CNT
);

  typedef enum logic [2:0] {
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_RELEASE,
    S_ERROR,
    S_LOCKOUT
  } state_t;

  localparam logic [3:0]  KEY_CLEAR = 4'hA;
  localparam logic [3:0]  KEY_ENTER = 4'hB;
  localparam logic [31:0] ERR_LAST  = (ERR_HOLD > 1) ? 32'(ERR_HOLD - 1) : 32'd0;
  localparam logic [31:0] LOCK_LAST = (LOCKOUT_DELAY > 1) ? 32'(LOCKOUT_DELAY - 1) : 32'd0;
  // FAIL_CNT is 2 bits wide, so the lockout threshold must be reachable within 1..3
  localparam int FAIL_LIMIT = (MAX_FAILS > 3) ? 3 : ((MAX_FAILS < 1) ? 1 : MAX_FAILS);

  state_t      state, state_nxt;
  logic [15:0] code_buf, code_buf_nxt;
  logic [31:0] timer_cnt, timer_cnt_nxt;
  logic [2:0]  digit_cnt_nxt;
  logic [1:0]  fail_cnt_nxt;
  logic [1:0]  fail_inc;
  logic        pw_ok_nxt, error_nxt, locked_nxt;
  logic        is_digit;
  logic        code_match;

  assign is_digit   = (KEY_CODE <= 4'd9);
  assign code_match = (DIGIT_CNT == 3'd4) && (code_buf == PASSWORD);
  assign fail_inc   = (FAIL_CNT == 2'd3) ? 2'd3 : FAIL_CNT + 2'd1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_ENTRY;
      code_buf   <= 16'h0000;
      timer_cnt  <= 32'd0;
      DIGIT_CNT  <= 3'd0;
      FAIL_CNT   <= 2'd0;
      PW_OK      <= 1'b0;
      ERROR      <= 1'b0;
      LOCKED_OUT <= 1'b0;
    end else begin
      state      <= state_nxt;
      code_buf   <= code_buf_nxt;
      timer_cnt  <= timer_cnt_nxt;
      DIGIT_CNT  <= digit_cnt_nxt;
      FAIL_CNT   <= fail_cnt_nxt;
      PW_OK      <= pw_ok_nxt;
      ERROR      <= error_nxt;
      LOCKED_OUT <= locked_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    code_buf_nxt  = code_buf;
    timer_cnt_nxt = timer_cnt;
    digit_cnt_nxt = DIGIT_CNT;
    fail_cnt_nxt  = FAIL_CNT;
    pw_ok_nxt     = PW_OK;
    error_nxt     = ERROR;
    locked_nxt    = LOCKED_OUT;

    case (state)
      S_ENTRY: begin
        if (KEY_VALID) begin
          if (is_digit) begin
            if (DIGIT_CNT < 3'd4) begin
              code_buf_nxt  = {code_buf[11:0], KEY_CODE};
              digit_cnt_nxt = DIGIT_CNT + 3'd1;
            end
          end else if (KEY_CODE == KEY_CLEAR) begin
            code_buf_nxt  = 16'h0000;
            digit_cnt_nxt = 3'd0;
          end else if (KEY_CODE == KEY_ENTER) begin
            state_nxt = S_CHECK;
          end
        end
      end

      S_CHECK: begin
        code_buf_nxt  = 16'h0000;
        digit_cnt_nxt = 3'd0;
        timer_cnt_nxt = 32'd0;
        if (code_match) begin
          state_nxt    = S_OPEN;
          pw_ok_nxt    = 1'b1;
          fail_cnt_nxt = 2'd0;
        end else begin
          fail_cnt_nxt = fail_inc;
          error_nxt    = 1'b1;
          if (int'(fail_inc) >= FAIL_LIMIT) begin
            state_nxt  = S_LOCKOUT;
            locked_nxt = 1'b1;
          end else begin
            state_nxt = S_ERROR;
          end
        end
      end

      S_OPEN: begin
        if (MOTOR_DONE) begin
          pw_ok_nxt = 1'b0;
          state_nxt = S_RELEASE;
        end
      end

      // wait for the sequencer to drop its done flag so the next open is a fresh request
      S_RELEASE: begin
        if (!MOTOR_DONE) state_nxt = S_ENTRY;
      end

      S_ERROR: begin
        if (timer_cnt >= ERR_LAST) begin
          timer_cnt_nxt = 32'd0;
          error_nxt     = 1'b0;
          state_nxt     = S_ENTRY;
        end else begin
          timer_cnt_nxt = timer_cnt + 32'd1;
        end
      end

      S_LOCKOUT: begin
        if (timer_cnt >= LOCK_LAST) begin
          timer_cnt_nxt = 32'd0;
          error_nxt     = 1'b0;
          locked_nxt    = 1'b0;
          fail_cnt_nxt  = 2'd0;
          state_nxt     = S_ENTRY;
        end else begin
          timer_cnt_nxt = timer_cnt + 32'd1;
        end
      end

      default: begin
        state_nxt = S_ENTRY;
      end
    endcase
  end

endmodule

// File: tb/tb_door_lock_controller.sv
// Bench for door_lock_controller: directed scenarios followed by random key sessions,
// checked against a digit-queue model of the lock.
module tb_door_lock_controller;

  localparam logic [15:0] PW   = 16'h1234;
  localparam int          MAXF = 3;
  localparam int          EH   = 4;
  localparam int          LD   = 20;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       KEY_VALID;
  logic [3:0] KEY_CODE;
  logic       MOTOR_DONE;
  logic       PW_OK;
  logic       ERROR;
  logic       LOCKED_OUT;
  logic [2:0] DIGIT_CNT;
  logic [1:0] FAIL_CNT;

  door_lock_controller #(
    .PASSWORD(PW), .MAX_FAILS(MAXF), .ERR_HOLD(EH), .LOCKOUT_DELAY(LD)
  ) dut (
    .CLK(CLK), .RESET(RESET), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
    .MOTOR_DONE(MOTOR_DONE), .PW_OK(PW_OK), .ERROR(ERROR), .LOCKED_OUT(LOCKED_OUT),
    .DIGIT_CNT(DIGIT_CNT), .FAIL_CNT(FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  // model: digits typed so far, consecutive failures, and whether keys are currently accepted
  int mq[$];
  int mfail = 0;
  bit m_entry = 1'b1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic bit model_match();
    if (mq.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      int d;
      d = int'(PW >> (12 - 4 * i)) & 15;
      if (mq[i] != d) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic press(input logic [3:0] k);
    @(negedge CLK);
    KEY_VALID = 1'b1;
    KEY_CODE  = k;
    @(negedge CLK);
    KEY_VALID = 1'b0;
    KEY_CODE  = 4'h0;
  endtask

  task automatic key(input logic [3:0] k);
    press(k);
    if (m_entry) begin
      if (k <= 4'd9) begin
        if (mq.size() < 4) mq.push_back(int'(k));
      end else if (k == 4'hA) begin
        mq.delete();
      end
    end
    chk("digit_cnt", DIGIT_CNT, mq.size());
  endtask

  task automatic type_pw();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
  endtask

  task automatic wait_low(input bit which, input int rise, input int exp, input string tag);
    int n;
    n = 0;
    while (((which == 1'b0) ? ERROR : LOCKED_OUT) === 1'b1 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk(tag, cyc - rise, exp);
  endtask

  task automatic do_open(input int hold);
    if (!MOTOR_DONE) begin
      repeat (hold) begin
        @(negedge CLK);
        chk("pw_ok_hold", PW_OK, 1);
      end
      MOTOR_DONE = 1'b1;
    end
    @(negedge CLK);
    chk("pw_ok_fall", PW_OK, 0);
    press(4'd5);
    press(4'd9);
    chk("release_digits", DIGIT_CNT, 0);
    chk("release_no_retrigger", PW_OK, 0);
    MOTOR_DONE = 1'b0;
    @(negedge CLK);
    chk("open_fail_cnt", FAIL_CNT, 0);
    m_entry = 1'b1;
    key(4'd7);
    key(4'hA);
  endtask

  task automatic run_enter(input int hold);
    bit match;
    int rise;
    match = model_match();
    press(4'hB);
    m_entry = 1'b0;
    chk("check_cycle_pw_ok", PW_OK, 0);
    @(negedge CLK);
    rise = cyc;
    mq.delete();
    chk("after_check_digits", DIGIT_CNT, 0);
    if (match) begin
      mfail = 0;
      chk("open_pw_ok", PW_OK, 1);
      chk("open_fail_cnt0", FAIL_CNT, 0);
      chk("open_error", ERROR, 0);
      do_open(hold);
    end else begin
      mfail++;
      chk("mismatch_fail_cnt", FAIL_CNT, mfail);
      chk("mismatch_pw_ok", PW_OK, 0);
      chk("mismatch_error", ERROR, 1);
      if (mfail >= MAXF) begin
        chk("lockout_flag", LOCKED_OUT, 1);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'hB);
        chk("lockout_digits", DIGIT_CNT, 0);
        chk("lockout_pw_ok", PW_OK, 0);
        chk("lockout_still", LOCKED_OUT, 1);
        wait_low(1'b1, rise, LD, "lockout_len");
        chk("lockout_end_error", ERROR, 0);
        chk("lockout_end_fail_cnt", FAIL_CNT, 0);
        mfail = 0;
      end else begin
        chk("error_no_lockout", LOCKED_OUT, 0);
        wait_low(1'b0, rise, EH, "error_len");
        chk("error_end_fail_cnt", FAIL_CNT, mfail);
      end
      m_entry = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pw_ok"}, PW_OK, 0);
    chk({tag, "_error"}, ERROR, 0);
    chk({tag, "_locked"}, LOCKED_OUT, 0);
    chk({tag, "_digit_cnt"}, DIGIT_CNT, 0);
    chk({tag, "_fail_cnt"}, FAIL_CNT, 0);
  endtask

  initial begin
    RESET = 1'b1;
    KEY_VALID = 1'b0;
    KEY_CODE = 4'h0;
    MOTOR_DONE = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RESET = 1'b0;

    // correct code with a long motor run
    type_pw();
    run_enter(10);

    // one wrong code
    key(4'd1); key(4'd2); key(4'd3); key(4'd5);
    run_enter(0);

    // reserved code ignored, then two more wrong codes trigger lockout
    key(4'hC); key(4'hF);
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    run_enter(0);
    run_enter(0);
    type_pw();
    run_enter(2);

    // fifth digit ignored, clear mid-entry, then a short code
    type_pw(); key(4'd5);
    run_enter(1);
    key(4'd1); key(4'd2); key(4'hA);
    type_pw();
    run_enter(3);
    key(4'd1); key(4'd2); key(4'd3);
    run_enter(0);

    // motor already done before entry: single-cycle open request
    MOTOR_DONE = 1'b1;
    key(4'd8);
    key(4'hA);
    type_pw();
    run_enter(0);

    // reset while the open request is active
    type_pw();
    press(4'hB);
    @(negedge CLK);
    chk("pre_reset_pw_ok", PW_OK, 1);
    RESET = 1'b1;
    @(negedge CLK);
    check_reset_outputs("reset_open");
    RESET = 1'b0;
    mq.delete();
    mfail = 0;
    m_entry = 1'b1;

    // random sessions
    for (int s = 0; s < 40; s++) begin
      int mode;
      int len;
      mode = int'($urandom_range(0, 2));
      if (mode != 0) begin
        len = int'($urandom_range(0, 6));
        for (int j = 0; j < len; j++) begin
          int kv;
          kv = int'($urandom_range(0, 14));
          if (kv >= 11) kv++;
          key(4'(kv));
        end
      end
      if (mode == 1) key(4'hA);
      if (mode != 2) type_pw();
      run_enter(int'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
